// File: rtl/ysyx_220066_lsu.sv
// ysyx_220066_lsu - memory-access stage of the pipeline.
//
// Registers one EX bundle. Loads and stores run one request/ack transaction
// on the data bus. Load data is aligned and extended, and the writeback
// bundle is then presented. Non-memory bundles pass straight through
// with one cycle of latency. EX is stalled while a bus transaction is
// outstanding, or while a finished bundle is held by a WB stall.
//
// Ports
//   clk, rst               clock, asynchronous active-low reset
//   valid_in .. rd_in      EX bundle: valid, upstream error, ALU result/address,
//                          store data, funct3 width/sign, load/store, rd write enable, rd
//   block                  WB stall: hold the presented bundle
//   stall_up               stall to EX
//   mem_req .. mem_wmask   data bus request: doubleword address, write enable,
//                          lane-shifted store data, byte enables
//   mem_ack .. mem_err     data bus response (1-cycle pulse) with read data / error
//   valid, rd, RegWr,      writeback bundle
//   result, error
module ysyx_220066_lsu #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_in,
    input  logic                  error_in,
    input  logic [63:0]           result_in,
    input  logic [DATA_W-1:0]     src2_in,
    input  logic [2:0]            MemOp_in,
    input  logic                  MemRd_in,
    input  logic                  MemWr_in,
    input  logic                  RegWr_in,
    input  logic [4:0]            rd_in,
    input  logic                  block,
    output logic                  stall_up,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wmask,
    input  logic                  mem_ack,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_err,
    output logic                  valid,
    output logic [4:0]            rd,
    output logic                  RegWr,
    output logic [63:0]           result,
    output logic                  error
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e                 state_q,  state_d;
    logic [ADDR_W-1:0]      addr_q,   addr_d;
    logic                   we_q,     we_d;
    logic [DATA_W-1:0]      wdata_q,  wdata_d;
    logic [DATA_W/8-1:0]    wmask_q,  wmask_d;
    logic [2:0]             op_q,     op_d;
    logic [2:0]             off_q,    off_d;
    logic [4:0]             rd_q,     rd_d;
    logic                   regwr_q,  regwr_d;
    logic [63:0]            result_q, result_d;
    logic                   error_q,  error_d;

    logic                   stall_c;
    logic                   accept;
    logic [2:0]             lane;
    logic                   is_mem;
    logic                   misaligned;
    logic                   bad_access;
    logic [DATA_W-1:0]      rshift;
    logic [63:0]            load_val;

    // Load alignment/extension works on the latched op and byte offset.
    always_comb begin
        rshift = mem_rdata >> {off_q, 3'b000};
        unique case (op_q)
            3'b000:  load_val = {{56{rshift[7]}},  rshift[7:0]};
            3'b001:  load_val = {{48{rshift[15]}}, rshift[15:0]};
            3'b010:  load_val = {{32{rshift[31]}}, rshift[31:0]};
            3'b100:  load_val = {56'd0, rshift[7:0]};
            3'b101:  load_val = {48'd0, rshift[15:0]};
            3'b110:  load_val = {32'd0, rshift[31:0]};
            default: load_val = rshift[63:0];
        endcase
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        wmask_d  = wmask_q;
        op_d     = op_q;
        off_d    = off_q;
        rd_d     = rd_q;
        regwr_d  = regwr_q;
        result_d = result_q;
        error_d  = error_q;

        stall_c = (state_q == REQ) || ((state_q == DONE) && block);
        accept  = valid_in && !stall_c;
        lane    = result_in[2:0];
        is_mem  = MemRd_in || MemWr_in;

        unique case (MemOp_in[1:0])
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = lane[0];
            2'b10:   misaligned = |lane[1:0];
            default: misaligned = |lane;
        endcase
        // Misaligned or simultaneous load+store: flagged, never reaches the bus.
        bad_access = is_mem && (misaligned || (MemRd_in && MemWr_in));

        if (accept) begin
            rd_d     = rd_in;
            regwr_d  = RegWr_in && !bad_access;
            result_d = result_in;
            error_d  = error_in || bad_access;
            addr_d   = {result_in[ADDR_W-1:3], 3'b000};
            we_d     = MemWr_in;
            op_d     = MemOp_in;
            off_d    = lane;
            wdata_d  = src2_in << {lane, 3'b000};
            unique case (MemOp_in[1:0])
                2'b00:   wmask_d = 8'h01 << lane;
                2'b01:   wmask_d = 8'h03 << lane;
                2'b10:   wmask_d = 8'h0F << lane;
                default: wmask_d = 8'hFF;
            endcase
            state_d  = (is_mem && !bad_access && !error_in) ? REQ : DONE;
        end else if (state_q == REQ) begin
            if (mem_ack) begin
                state_d = DONE;
                if (mem_err) begin
                    error_d = 1'b1;
                    regwr_d = 1'b0;
                end else if (!we_q) begin
                    result_d = load_val;
                end
            end
        end else if (!stall_c) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            wmask_q  <= '0;
            op_q     <= '0;
            off_q    <= '0;
            rd_q     <= '0;
            regwr_q  <= 1'b0;
            result_q <= '0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            wmask_q  <= wmask_d;
            op_q     <= op_d;
            off_q    <= off_d;
            rd_q     <= rd_d;
            regwr_q  <= regwr_d;
            result_q <= result_d;
            error_q  <= error_d;
        end
    end

    // Request and valid decode the state register directly, so an
    // asynchronous reset drops them at once.
    assign stall_up  = stall_c;
    assign mem_req   = (state_q == REQ);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wmask = wmask_q;
    assign valid     = (state_q == DONE);
    assign rd        = rd_q;
    assign RegWr     = regwr_q;
    assign result    = result_q;
    assign error     = error_q;

endmodule

// File: tb/tb_ysyx_220066_lsu.sv
module tb_ysyx_220066_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in, error_in;
    logic [63:0] result_in, src2_in;
    logic [2:0]  MemOp_in;
    logic        MemRd_in, MemWr_in, RegWr_in;
    logic [4:0]  rd_in;
    logic        block;
    logic        stall_up, mem_req, mem_we;
    logic [63:0] mem_addr, mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_ack;
    logic [63:0] mem_rdata;
    logic        mem_err;
    logic        valid;
    logic [4:0]  rd;
    logic        RegWr;
    logic [63:0] result;
    logic        error;

    ysyx_220066_lsu #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk(clk), .rst(rst),
        .valid_in(valid_in), .error_in(error_in), .result_in(result_in),
        .src2_in(src2_in), .MemOp_in(MemOp_in), .MemRd_in(MemRd_in),
        .MemWr_in(MemWr_in), .RegWr_in(RegWr_in), .rd_in(rd_in),
        .block(block), .stall_up(stall_up),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_err(mem_err),
        .valid(valid), .rd(rd), .RegWr(RegWr), .result(result), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        logic        we;
        logic [63:0] wdata;
        logic [7:0]  wmask;
        int          delay;
        logic [63:0] rdata;
        logic        merr;
    } bus_t;

    typedef struct {
        logic [63:0] result;
        logic [4:0]  rd;
        logic        regwr;
        logic        err;
    } wb_t;

    bus_t bus_q[$];
    wb_t  wb_q[$];
    int   bus_rd = 0;
    int   wb_rd  = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   req_cycles = 0;
    logic force_ack = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] exp_load(input logic [2:0] op, input logic [2:0] a,
                                             input logic [63:0] d);
        logic [63:0] s;
        logic [63:0] r;
        int n;
        s = d >> (8 * int'(a));
        n = 1 << op[1:0];
        r = '0;
        for (int i = 0; i < n; i++) r[8*i +: 8] = s[8*i +: 8];
        if (op[2] == 1'b0 && op[1:0] != 2'b11 && s[8*n-1])
            for (int i = n; i < 8; i++) r[8*i +: 8] = 8'hFF;
        return r;
    endfunction

    function automatic logic [7:0] exp_mask(input logic [2:0] op, input logic [2:0] a);
        logic [15:0] m;
        m = ((16'h1 << (1 << op[1:0])) - 16'h1) << a;
        return m[7:0];
    endfunction

    // Drives one bundle for one accepting edge and records what the bus and
    // the writeback port should show for it.
    task automatic issue(input logic [63:0] res, input logic [63:0] src2, input logic [2:0] op,
                         input logic rdv, input logic wrv, input logic regwr, input logic errin,
                         input logic [4:0] rdn, input int delay, input logic [63:0] rdata,
                         input logic merr, input logic abort);
        logic mem, bad, bus_go;
        logic [2:0] a;
        bus_t b;
        wb_t  w;
        for (int i = 0; i < 50 && stall_up; i++) begin
            @(posedge clk);
            #1;
        end
        if (stall_up) check_eq("issue_stall_timeout", {63'd0, stall_up}, 64'd0);
        a      = res[2:0];
        mem    = rdv | wrv;
        bad    = mem && (((int'(a) & ((1 << op[1:0]) - 1)) != 0) || (rdv && wrv));
        bus_go = mem && !bad && !errin;
        if (bus_go) begin
            b.addr  = {res[63:3], 3'b000};
            b.we    = wrv;
            b.wdata = src2 << (8 * int'(a));
            b.wmask = exp_mask(op, a);
            b.delay = delay;
            b.rdata = rdata;
            b.merr  = merr;
            bus_q.push_back(b);
        end
        if (!abort) begin
            w.rd     = rdn;
            w.err    = errin | bad | (bus_go & merr);
            w.regwr  = (bad || (bus_go && merr)) ? 1'b0 : regwr;
            w.result = (bus_go && rdv && !merr) ? exp_load(op, a, rdata) : res;
            wb_q.push_back(w);
        end
        valid_in = 1'b1; result_in = res; src2_in = src2; MemOp_in = op;
        MemRd_in = rdv; MemWr_in = wrv; RegWr_in = regwr; error_in = errin; rd_in = rdn;
        @(posedge clk);
        #1;
        valid_in = 1'b0; MemRd_in = 1'b0; MemWr_in = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && (wb_rd < wb_q.size() || bus_rd < bus_q.size() || valid); i++)
            @(negedge clk);
        check_eq("drain_wb", 64'(wb_q.size() - wb_rd), 64'd0);
        check_eq("drain_bus", 64'(bus_q.size() - bus_rd), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // Bus responder and writeback scoreboard, both sampled on the falling edge.
    initial begin
        int   wait_cnt = 0;
        logic serving  = 1'b0;
        bus_t b;
        wb_t  e;
        forever begin
            @(negedge clk);
            mem_ack   = force_ack;
            mem_err   = 1'b0;
            mem_rdata = force_ack ? '1 : '0;
            if (!rst) begin
                if (serving) bus_rd++;
                serving  = 1'b0;
                wait_cnt = 0;
            end else begin
                if (mem_req) begin
                    req_cycles++;
                    if (bus_rd >= bus_q.size()) begin
                        check_eq("unexpected_req", {63'd0, mem_req}, 64'd0);
                    end else begin
                        b = bus_q[bus_rd];
                        serving = 1'b1;
                        check_eq("mem_addr", mem_addr, b.addr);
                        check_eq("mem_we", {63'd0, mem_we}, {63'd0, b.we});
                        check_eq("stall_in_req", {63'd0, stall_up}, 64'd1);
                        if (b.we) begin
                            check_eq("mem_wdata", mem_wdata, b.wdata);
                            check_eq("mem_wmask", {56'd0, mem_wmask}, {56'd0, b.wmask});
                        end
                        if (wait_cnt == b.delay) begin
                            mem_ack   = 1'b1;
                            mem_rdata = b.rdata;
                            mem_err   = b.merr;
                            bus_rd++;
                            serving  = 1'b0;
                            wait_cnt = 0;
                        end else begin
                            wait_cnt++;
                        end
                    end
                end
                if (valid && !block) begin
                    if (wb_rd >= wb_q.size()) begin
                        check_eq("unexpected_valid", {63'd0, valid}, 64'd0);
                    end else begin
                        e = wb_q[wb_rd];
                        wb_rd++;
                        check_eq("wb_result", result, e.result);
                        check_eq("wb_rd", {59'd0, rd}, {59'd0, e.rd});
                        check_eq("wb_regwr", {63'd0, RegWr}, {63'd0, e.regwr});
                        check_eq("wb_error", {63'd0, error}, {63'd0, e.err});
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [2:0]  ops  [6] = '{3'b100, 3'b001, 3'b101, 3'b010, 3'b110, 3'b011};
        logic [2:0]  offs [6] = '{3'd5,   3'd2,   3'd6,   3'd4,   3'd4,   3'd0};
        logic [2:0]  sops [3] = '{3'b000, 3'b010, 3'b011};
        logic [2:0]  soffs[3] = '{3'd7,   3'd4,   3'd0};
        logic [63:0] rdv;

        rst = 1'b0; valid_in = 1'b0; error_in = 1'b0; result_in = '0; src2_in = '0;
        MemOp_in = '0; MemRd_in = 1'b0; MemWr_in = 1'b0; RegWr_in = 1'b0; rd_in = '0;
        block = 1'b0; mem_ack = 1'b0; mem_rdata = '0; mem_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_valid", {63'd0, valid}, 64'd0);
        check_eq("rst_mem_req", {63'd0, mem_req}, 64'd0);
        check_eq("rst_stall_up", {63'd0, stall_up}, 64'd0);
        check_eq("rst_error", {63'd0, error}, 64'd0);
        check_eq("rst_result", result, 64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Non-memory pass-through, one cycle latency.
        issue(64'h1234, 64'd0, 3'b011, 1'b0, 1'b0, 1'b1, 1'b0, 5'd5, 0, 64'd0, 1'b0, 1'b0);
        @(negedge clk);
        check_eq("nonmem_latency_valid", {63'd0, valid}, 64'd1);
        check_eq("nonmem_no_req", {63'd0, mem_req}, 64'd0);
        drain();

        // lb with sign extension from byte lane 3.
        issue(64'h8000_0003, 64'd0, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 5'd7, 1,
              64'h0000_0000_8000_0000, 1'b0, 1'b0);
        drain();

        // sh to the top halfword lane.
        issue(64'h8000_0006, 64'hABCD, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 2,
              64'd0, 1'b0, 1'b0);
        drain();

        // Misaligned lw: no bus access, error, RegWr cleared.
        issue(64'h8000_0002, 64'd0, 3'b010, 1'b1, 1'b0, 1'b1, 1'b0, 5'd9, 0,
              64'd0, 1'b0, 1'b0);
        @(negedge clk);
        check_eq("misaligned_latency_valid", {63'd0, valid}, 64'd1);
        drain();

        // Load widths, offsets and extensions.
        foreach (ops[i]) begin
            rdv = {$urandom, $urandom};
            if (i == 3) rdv[63] = 1'b1;
            issue({32'h0, 32'h8000_0100} + 64'(offs[i]), 64'd0, ops[i], 1'b1, 1'b0, 1'b1, 1'b0,
                  5'(i + 10), i % 3, rdv, 1'b0, 1'b0);
        end
        drain();

        // Store widths and lanes.
        foreach (sops[i]) begin
            issue({32'h0, 32'h8000_0200} + 64'(soffs[i]), {$urandom, $urandom}, sops[i],
                  1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1, 64'd0, 1'b0, 1'b0);
        end
        drain();

        // Back-to-back non-memory bundles, one per cycle.
        issue(64'hAAAA, 64'd0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 5'd1, 0, 64'd0, 1'b0, 1'b0);
        check_eq("b2b_stall_1", {63'd0, stall_up}, 64'd0);
        issue(64'hBBBB, 64'd0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 5'd2, 0, 64'd0, 1'b0, 1'b0);
        check_eq("b2b_stall_2", {63'd0, stall_up}, 64'd0);
        issue(64'hCCCC, 64'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3, 0, 64'd0, 1'b0, 1'b0);
        drain();

        // Bus error, upstream error, and load+store together.
        issue(64'h8000_0008, 64'd0, 3'b011, 1'b1, 1'b0, 1'b1, 1'b0, 5'd4, 1,
              64'h5555, 1'b1, 1'b0);
        issue(64'h7777, 64'd0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 5'd6, 0, 64'd0, 1'b0, 1'b0);
        issue(64'h8000_0010, 64'h1, 3'b011, 1'b1, 1'b1, 1'b1, 1'b0, 5'd8, 0,
              64'd0, 1'b0, 1'b0);
        drain();

        // Slow ack, then WB stall held for three cycles in DONE.
        req_cycles = 0;
        issue(64'h8000_0010, 64'd0, 3'b011, 1'b1, 1'b0, 1'b1, 1'b0, 5'd12, 4,
              64'h1122_3344_5566_7788, 1'b0, 1'b0);
        block = 1'b1;
        for (int i = 0; i < 20 && !valid; i++) @(negedge clk);
        check_eq("slow_req_cycles", 64'(req_cycles), 64'd5);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            check_eq("block_valid", {63'd0, valid}, 64'd1);
            check_eq("block_stall_up", {63'd0, stall_up}, 64'd1);
            check_eq("block_result", result, 64'h1122_3344_5566_7788);
            check_eq("block_mem_req", {63'd0, mem_req}, 64'd0);
        end
        @(posedge clk);
        #1;
        block = 1'b0;
        drain();

        // Reset during an outstanding request, then a stray ack.
        issue(64'h8000_0020, 64'd0, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 5'd13, 30,
              64'hFF, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        check_eq("abort_req_before", {63'd0, mem_req}, 64'd1);
        #2;
        rst = 1'b0;
        #1;
        check_eq("abort_mem_req", {63'd0, mem_req}, 64'd0);
        check_eq("abort_valid", {63'd0, valid}, 64'd0);
        check_eq("abort_stall_up", {63'd0, stall_up}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        force_ack = 1'b1;
        @(posedge clk);
        #1;
        force_ack = 1'b0;
        @(negedge clk);
        check_eq("stray_ack_valid", {63'd0, valid}, 64'd0);
        check_eq("stray_ack_req", {63'd0, mem_req}, 64'd0);
        check_eq("stray_ack_stall", {63'd0, stall_up}, 64'd0);
        @(posedge clk);
        #1;
        issue(64'h4242, 64'd0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 5'd14, 0, 64'd0, 1'b0, 1'b0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
